// File: rtl/lif_scheduler.sv
// ---------------------------------------------------------------------------
// lif_scheduler
//
// Time-multiplexed leaky integrate-and-fire controller. One LIF update path
// is shared by N_NEURONS neurons whose membrane states live in an internal
// state file. A timestep of currents is accepted on a valid/ready handshake,
// the neurons are swept one per cycle, and the resulting spike vector is
// presented on a valid/ready output.
//
// Build option:
//   LIF_SCHED_SOFT_RESET_EN  defined   -> firing neuron keeps sum - THRESHOLD
//                            undefined -> firing neuron returns to 0
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   in_valid    timestep packet offered
//   in_ready    scheduler can accept a packet (high only in IDLE)
//   in_current  N_NEURONS unsigned currents, neuron i at [i*WIDTH +: WIDTH]
//   out_valid   spike vector of the completed timestep available
//   out_ready   consumer accepts the spike vector
//   out_spikes  bit i = neuron i fired this timestep
//   busy        high while updating or emitting
//   step_count  completed timesteps, wraps 0xFFFF -> 0
//   rd_idx      state readout select
//   rd_state    state of neuron rd_idx as of the previous edge
// ---------------------------------------------------------------------------
module lif_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*WIDTH-1:0]    in_current,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS-1:0]          out_spikes,
  output logic                          busy,
  output logic [15:0]                   step_count,
  input  logic [$clog2(N_NEURONS)-1:0]  rd_idx,
  output logic [WIDTH-1:0]              rd_state
);

  localparam int IDX_W = $clog2(N_NEURONS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t                       state_r;
  state_t                       state_next_s;
  logic [IDX_W-1:0]             idx_r;
  logic [N_NEURONS*WIDTH-1:0]   cur_r;
  logic [WIDTH-1:0]             mem_r [N_NEURONS];
  logic [N_NEURONS-1:0]         spikes_r;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic                         busy_r;
  logic [15:0]                  step_count_r;
  logic [WIDTH-1:0]             rd_state_r;

  logic                         accept_s;
  logic                         update_s;
  logic                         done_s;
  logic                         last_s;
  logic [WIDTH-1:0]             cur_sel_s;
  logic [WIDTH-1:0]             state_sel_s;
  logic [WIDTH-1:0]             rd_next_s;
  logic [WIDTH-1:0]             leak_s;
  logic [WIDTH:0]               sum_wide_s;
  logic [WIDTH-1:0]             sat_s;
  logic                         fire_s;
  logic [WIDTH-1:0]             post_fire_s;
  logic [WIDTH-1:0]             new_state_s;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_spikes = spikes_r;
  assign busy       = busy_r;
  assign step_count = step_count_r;
  assign rd_state   = rd_state_r;

  // Select the current and state of the neuron being swept, and the readout neuron.
  always_comb begin
    cur_sel_s   = {WIDTH{1'b0}};
    state_sel_s = {WIDTH{1'b0}};
    rd_next_s   = {WIDTH{1'b0}};
    for (int i = 0; i < N_NEURONS; i++) begin
      cur_sel_s   = (idx_r  == IDX_W'(i)) ? cur_r[i*WIDTH +: WIDTH] : cur_sel_s;
      state_sel_s = (idx_r  == IDX_W'(i)) ? mem_r[i]                : state_sel_s;
      rd_next_s   = (rd_idx == IDX_W'(i)) ? mem_r[i]                : rd_next_s;
    end
  end

  // Shared LIF update: leak, integrate with saturation, threshold, post-fire value.
  always_comb begin
    leak_s     = state_sel_s >> LEAK_SHIFT;
    // One extra bit catches the carry so the sum can clamp instead of wrapping.
    sum_wide_s = {1'b0, cur_sel_s} + {1'b0, leak_s};
    sat_s      = sum_wide_s[WIDTH] ? {WIDTH{1'b1}} : sum_wide_s[WIDTH-1:0];
    fire_s     = (sat_s >= WIDTH'(THRESHOLD));
`ifdef LIF_SCHED_SOFT_RESET_EN
    // Residue above threshold carries into the next timestep.
    post_fire_s = sat_s - WIDTH'(THRESHOLD);
`else
    post_fire_s = {WIDTH{1'b0}};
`endif
    new_state_s = fire_s ? post_fire_s : sat_s;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    update_s     = 1'b0;
    done_s       = 1'b0;
    last_s       = (idx_r == IDX_W'(N_NEURONS - 1));
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = UPDATE;
        end else begin
          state_next_s = IDLE;
        end
      end
      UPDATE: begin
        update_s     = 1'b1;
        state_next_s = last_s ? EMIT : UPDATE;
      end
      EMIT: begin
        if (out_ready) begin
          done_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = EMIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake and status flags, registered from the next state so none depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == EMIT);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Sweep index and latched currents for the timestep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= {IDX_W{1'b0}};
      cur_r <= {(N_NEURONS*WIDTH){1'b0}};
    end else if (accept_s) begin
      idx_r <= {IDX_W{1'b0}};
      cur_r <= in_current;
    end else if (update_s && !last_s) begin
      idx_r <= idx_r + IDX_W'(1'b1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Spike vector: cleared on acceptance, one bit written per update.
  always_ff @(posedge clk) begin
    if (reset) begin
      spikes_r <= {N_NEURONS{1'b0}};
    end else if (accept_s) begin
      spikes_r <= {N_NEURONS{1'b0}};
    end else if (update_s) begin
      spikes_r[idx_r] <= fire_s;
    end else begin
      spikes_r <= spikes_r;
    end
  end

  // Membrane state file, written only for the neuron being swept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (update_s && (idx_r == IDX_W'(i))) begin
          mem_r[i] <= new_state_s;
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Completed-timestep counter, advanced on the output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_count_r <= 16'd0;
    end else if (done_s) begin
      step_count_r <= step_count_r + 16'd1;
    end else begin
      step_count_r <= step_count_r;
    end
  end

  // State readout; samples the file before this edge's update lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= {WIDTH{1'b0}};
    end else begin
      rd_state_r <= rd_next_s;
    end
  end

endmodule
